// File: rtl/dmadd_host.sv
// dmadd_host: host-side sequencer for the DMADD engine pin interface.
// Accepts a job start and (index, data) load beats, then drives the DMADD
// clear / init / load / run pins. It captures the 12-bit result and returns it on a handshake.
module dmadd_host #(
    parameter int unsigned RUN_CYCLES = 16,
    parameter int unsigned MAX_BEATS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  start_op,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_index,
    input  logic [3:0]  cmd_data,
    input  logic        cmd_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        res_err,
    output logic        dm_rst_n,
    output logic        dm_run,
    output logic        dm_load,
    output logic [1:0]  dm_insn,
    output logic [3:0]  dm_index,
    output logic [3:0]  dm_data,
    input  logic [11:0] dm_out
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OP_W  = 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_INIT    = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_RESULT  = 3'd6;

    localparam logic [OP_W-1:0]  OP_RSVD   = 2'b11;
    localparam logic [CNT_W-1:0] RUN_LEN   = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] BEAT_LIM  = CNT_W'(MAX_BEATS);

    logic [2:0]       state, state_nxt;
    logic [OP_W-1:0]  op, op_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0] run_cnt, run_cnt_nxt;

    logic        start_ready_nxt;
    logic        cmd_ready_nxt;
    logic        res_valid_nxt;
    logic [11:0] res_data_nxt;
    logic        res_err_nxt;
    logic        dm_rst_n_nxt;
    logic        dm_run_nxt;
    logic        dm_load_nxt;
    logic [1:0]  dm_insn_nxt;
    logic [3:0]  dm_index_nxt;
    logic [3:0]  dm_data_nxt;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op          <= '0;
            beat_cnt    <= '0;
            run_cnt     <= '0;
            start_ready <= 1'b0;
            cmd_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            dm_rst_n    <= 1'b1;
            dm_run      <= 1'b0;
            dm_load     <= 1'b0;
            dm_insn     <= '0;
            dm_index    <= '0;
            dm_data     <= '0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            beat_cnt    <= beat_cnt_nxt;
            run_cnt     <= run_cnt_nxt;
            start_ready <= start_ready_nxt;
            cmd_ready   <= cmd_ready_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            res_err     <= res_err_nxt;
            dm_rst_n    <= dm_rst_n_nxt;
            dm_run      <= dm_run_nxt;
            dm_load     <= dm_load_nxt;
            dm_insn     <= dm_insn_nxt;
            dm_index    <= dm_index_nxt;
            dm_data     <= dm_data_nxt;
        end
    end

    // Next state and next-cycle pin values; outputs reflect the state being entered
    always_comb begin
        state_nxt    = state;
        op_nxt       = op;
        beat_cnt_nxt = beat_cnt;
        run_cnt_nxt  = run_cnt;
        res_valid_nxt = res_valid;
        res_data_nxt  = res_data;
        res_err_nxt   = res_err;
        dm_rst_n_nxt  = 1'b1;
        dm_run_nxt    = 1'b0;
        dm_load_nxt   = 1'b0;
        dm_insn_nxt   = dm_insn;
        dm_index_nxt  = dm_index;
        dm_data_nxt   = dm_data;

        case (state)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    op_nxt       = start_op;
                    beat_cnt_nxt = '0;
                    if (start_op == OP_RSVD) begin
                        state_nxt     = S_RESULT;
                        res_valid_nxt = 1'b1;
                        res_err_nxt   = 1'b1;
                        res_data_nxt  = '0;
                    end else begin
                        state_nxt    = S_CLEAR;
                        dm_rst_n_nxt = 1'b0;
                        dm_insn_nxt  = '0;
                        dm_index_nxt = '0;
                        dm_data_nxt  = '0;
                    end
                end
            end
            S_CLEAR: begin
                state_nxt   = S_INIT;
                dm_insn_nxt = op;
            end
            S_INIT: begin
                state_nxt   = S_LOAD;
                dm_insn_nxt = op;
            end
            S_LOAD: begin
                dm_insn_nxt = op;
                if (cmd_valid && cmd_ready) begin
                    if (!cmd_last && (beat_cnt == BEAT_LIM)) begin
                        // overflow beat is dropped and the job aborts
                        state_nxt     = S_RESULT;
                        res_valid_nxt = 1'b1;
                        res_err_nxt   = 1'b1;
                        res_data_nxt  = '0;
                    end else begin
                        dm_load_nxt  = 1'b1;
                        dm_index_nxt = cmd_index;
                        dm_data_nxt  = cmd_data;
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                        if (cmd_last) begin
                            state_nxt   = S_RUN;
                            run_cnt_nxt = RUN_LEN;
                        end
                    end
                end
            end
            S_RUN: begin
                // first RUN cycle still shows the final load; run pulses follow back-to-back
                if (run_cnt != '0) begin
                    dm_run_nxt  = 1'b1;
                    run_cnt_nxt = run_cnt - CNT_W'(1);
                end else begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt     = S_RESULT;
                res_data_nxt  = dm_out;
                res_valid_nxt = 1'b1;
                res_err_nxt   = 1'b0;
            end
            S_RESULT: begin
                if (res_valid && res_ready) begin
                    state_nxt     = S_IDLE;
                    res_valid_nxt = 1'b0;
                    res_err_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        start_ready_nxt = (state_nxt == S_IDLE);
        cmd_ready_nxt   = (state_nxt == S_LOAD);
    end

endmodule

// File: tb/tb_dmadd_host.sv
// tb_dmadd_host: directed self-checking bench for dmadd_host.
module tb_dmadd_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  start_op;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_index;
    logic [3:0]  cmd_data;
    logic        cmd_last;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        res_err;
    logic        dm_rst_n;
    logic        dm_run;
    logic        dm_load;
    logic [1:0]  dm_insn;
    logic [3:0]  dm_index;
    logic [3:0]  dm_data;
    logic [11:0] dm_out;

    int checks = 0;
    int errors = 0;
    int n;

    dmadd_host #(.RUN_CYCLES(16), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_op(start_op),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_data(cmd_data), .cmd_last(cmd_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .dm_rst_n(dm_rst_n), .dm_run(dm_run), .dm_load(dm_load), .dm_insn(dm_insn),
        .dm_index(dm_index), .dm_data(dm_data), .dm_out(dm_out)
    );

    always #5 clk = ~clk;

    // one cycle: across the rising edge, land on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start a job and walk CLEAR / INIT into the first LOAD cycle
    task automatic start_job(input logic [1:0] op);
        start_valid = 1'b1;
        start_op    = op;
        tick();
        start_valid = 1'b0;
        chk("clear_rst_n", 32'(dm_rst_n), 0);
        chk("clear_insn", 32'(dm_insn), 0);
        chk("clear_start_ready", 32'(start_ready), 0);
        tick();
        chk("init_rst_n", 32'(dm_rst_n), 1);
        chk("init_insn", 32'(dm_insn), 32'(op));
        chk("init_cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("load_cmd_ready", 32'(cmd_ready), 1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("consume_res_valid", 32'(res_valid), 0);
        chk("consume_start_ready", 32'(start_ready), 1);
    endtask

    // hard bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bi [3];
        logic [3:0] bd [3];
        bi = '{4'd2, 4'd7, 4'd9};
        bd = '{4'd3, 4'd1, 4'd4};

        rst_n = 1'b1;
        start_valid = 1'b0; start_op = 2'b00;
        cmd_valid = 1'b0; cmd_index = '0; cmd_data = '0; cmd_last = 1'b0;
        res_ready = 1'b0; dm_out = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_flags", 32'({start_ready, cmd_ready, res_valid, res_err, dm_rst_n, dm_run, dm_load}), 32'b0000100);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_pins", 32'({dm_insn, dm_index, dm_data}), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_start_ready", 32'(start_ready), 1);

        // MIN job, single beat
        dm_out = 12'h005;
        start_job(2'b00);
        cmd_valid = 1'b1; cmd_index = 4'd5; cmd_data = 4'd1; cmd_last = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_last = 1'b0;
        chk("min_load", 32'({dm_load, dm_run, dm_index, dm_data}), 32'b10_0101_0001);
        chk("min_cmd_ready_off", 32'(cmd_ready), 0);
        n = 0;
        repeat (16) begin
            tick();
            if (dm_run && !dm_load) n++;
        end
        chk("min_run_cycles", 32'(n), 16);
        tick();
        chk("min_capture_run", 32'(dm_run), 0);
        chk("min_capture_valid", 32'(res_valid), 0);
        tick();
        chk("min_res_valid", 32'(res_valid), 1);
        chk("min_res_data", 32'(res_data), 32'h005);
        chk("min_res_err", 32'(res_err), 0);
        consume();

        // MADD job, three beats with single-cycle gaps
        dm_out = 12'hABC;
        start_job(2'b10);
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_index = bi[k]; cmd_data = bd[k]; cmd_last = (k == 2);
            tick();
            cmd_valid = 1'b0; cmd_last = 1'b0;
            chk("multi_load", 32'({dm_load, dm_run, dm_index, dm_data}), 32'({2'b10, bi[k], bd[k]}));
            if (k < 2) begin
                tick();
                chk("multi_gap", 32'(dm_load), 0);
            end
        end
        tick();
        chk("multi_run_b2b", 32'({dm_run, dm_load}), 32'b10);
        chk("multi_run_insn", 32'(dm_insn), 32'b10);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("multi_res_valid", 32'(res_valid), 1);
        chk("multi_latency", 32'(n), 17);
        chk("multi_res_data", 32'(res_data), 32'hABC);
        consume();

        // overflow: 17 beats without last
        start_job(2'b01);
        n = 0;
        for (int i = 0; i < 17; i++) begin
            cmd_valid = 1'b1; cmd_index = 4'(i); cmd_data = 4'(15 - i); cmd_last = 1'b0;
            tick();
            if (i < 16) begin
                chk("ovf_load", 32'({dm_load, dm_index}), 32'({1'b1, 4'(i)}));
                if (dm_load) n++;
            end else begin
                chk("ovf_drop_load", 32'(dm_load), 0);
                chk("ovf_err", 32'({res_valid, res_err, cmd_ready}), 32'b110);
                chk("ovf_res_data", 32'(res_data), 0);
            end
        end
        cmd_valid = 1'b0;
        chk("ovf_load_count", 32'(n), 16);
        consume();

        // reserved op with result backpressure
        dm_out = 12'h777;
        start_valid = 1'b1; start_op = 2'b11;
        tick();
        chk("rsvd_no_clear", 32'(dm_rst_n), 1);
        chk("rsvd_result", 32'({res_valid, res_err, cmd_ready}), 32'b110);
        chk("rsvd_res_data", 32'(res_data), 0);
        repeat (10) begin
            tick();
            chk("bp_hold", 32'({res_valid, res_err, start_ready, dm_rst_n, res_data}), 32'({4'b1101, 12'h000}));
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_release", 32'({res_valid, res_err, start_ready}), 32'b001);

        // reset in the middle of RUN
        dm_out = 12'h005;
        start_job(2'b00);
        cmd_valid = 1'b1; cmd_index = 4'd3; cmd_data = 4'd6; cmd_last = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_last = 1'b0;
        repeat (4) tick();
        chk("midrun_active", 32'(dm_run), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_flags", 32'({start_ready, cmd_ready, res_valid, res_err, dm_rst_n, dm_run, dm_load}), 32'b0000100);
        chk("midrun_rst_pins", 32'({dm_insn, dm_index, dm_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrun_idle", 32'(start_ready), 1);
        n = 0;
        repeat (25) begin
            tick();
            if (res_valid || dm_run) n++;
        end
        chk("midrun_no_result", 32'(n), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmadd_host.md
# dmadd_host

Host-side sequencer that drives the delta-MADD (DMADD) engine's pin interface. It accepts a job start (operation select) and a stream of (index, data) load beats over valid/ready handshakes. It then generates the DMADD clear / initialise / load / run pin sequence, samples the engine's 12-bit result after a programmable run length, and returns it on a result handshake. It sits between the top-level I/O wrapper and the DMADD instance.

## Interface

- RUN_CYCLES, 16: number of consecutive cycles `dm_run` is held high per job (1..255).
- MAX_BEATS, 16: load beats allowed per job before overflow error.

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  job start request
- start_ready  out  1  high only in IDLE
- start_op  in  2  DMADD instruction: 00 MIN, 01 MAX, 10 MADD, 11 reserved
- cmd_valid  in  1  load beat valid
- cmd_ready  out  1  high only in LOAD
- cmd_index  in  4  memory cell index
- cmd_data  in  4  data nibble
- cmd_last  in  1  final beat of job
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  12  captured DMADD `out`
- res_err  out  1  job aborted (reserved op or beat overflow)
- dm_rst_n  out  1  to DMADD reset, active low
- dm_run, dm_load  out  1 each  to DMADD
- dm_insn  out  2  to DMADD
- dm_index, dm_data  out  4 each  to DMADD
- dm_out  in  12  from DMADD

## Operation

- All outputs registered. Reset values: start_ready 0, cmd_ready 0, res_valid 0, res_data 0, res_err 0, dm_rst_n 1, dm_run 0, dm_load 0, dm_insn 00, dm_index 0, dm_data 0; state IDLE; counters 0. `start_ready` rises the first cycle after reset deasserts.
- States: IDLE, CLEAR, INIT, LOAD, RUN, CAPTURE, RESULT.
- IDLE: start_ready=1. On start_valid: latch start_op. If op=11, go to RESULT with res_err=1 and res_data=0. Otherwise go to CLEAR.
- CLEAR (1 cycle): dm_rst_n=0, all other dm_* 0.
- INIT (1 cycle): dm_run=0, dm_load=0, dm_insn=op.
- LOAD: cmd_ready=1, dm_insn=op.
  - An accepted beat drives dm_load=1, dm_index, dm_data in the following cycle; with no beat, dm_load=0.
  - The beat counter (8-bit) increments per accepted beat.
  - A beat with cmd_last=1 moves to RUN.
  - Accepting a beat when the counter already equals MAX_BEATS without last: drop it, res_err=1, go to RESULT.
- RUN: dm_run=1, dm_load=0 for exactly RUN_CYCLES cycles, counted by an 8-bit down-counter; then go to CAPTURE.
- CAPTURE (1 cycle): dm_run=0; res_data <= dm_out at end of cycle; go to RESULT.
- RESULT: res_valid=1, res_data and res_err stable. On res_ready, clear res_valid and res_err, then go to IDLE.
- dm_load and dm_run are never high in the same cycle. dm_rst_n is low only in CLEAR or during rst_n.
- rst_n low at any time: immediate return to reset values. An in-flight job is discarded and no result is produced.

## Timing

- Start accepted at edge T → CLEAR during cycle T+1, INIT T+2, LOAD from T+3 (cmd_ready=1 in T+3).
- Beat accepted at edge L → dm_load/index/data valid in cycle L+1.
- Last beat at edge L → dm_run=1 in cycles L+2 .. L+1+RUN_CYCLES.
  - The final load drive (L+1) and the first run cycle (L+2) are back-to-back.
- CAPTURE in cycle L+2+RUN_CYCLES; res_valid=1 from cycle L+3+RUN_CYCLES.
- Result consumed at edge R → start_ready=1 in cycle R+1.
- A new job cannot start until the result is consumed. No overlap, no pipelining.
- cmd_valid outside LOAD is ignored (cmd_ready=0).

## Test plan

- Reset: rst_n low mid-RUN → all outputs at reset values next sample, dm_rst_n=1, state IDLE; no res_valid after release.
- MIN job: op=00, single beat index=5 data=1 last=1 → pin trace CLEAR, INIT, load(5,1), 16 run cycles. With a DMADD model returning 5 → res_data=0x005, res_err=0, res_valid at L+19.
- Multi-beat with gaps: 3 beats (2,3),(7,1),(9,4) with one idle cycle between → dm_load pulses mirror gaps exactly, then RUN follows the third load with no gap.
- Reserved op: start_op=11 → no CLEAR (dm_rst_n stays 1), res_valid next cycle with res_err=1, res_data=0.
- Overflow: 17 beats, none last → 16 loads driven, 17th dropped (no dm_load), res_err=1.
- Backpressure: hold res_ready=0 for 10 cycles → res_valid and res_data stable, start_ready=0, start_valid ignored; release → start_ready=1 one cycle later.
